// File: rtl/axis_packet_arbiter_if.sv
// Stream bundle between N AXI-Stream sources and the merged output.
// master is the arbiter's view; slave is the sources/sink environment.
interface axis_packet_arbiter_if #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int SRC_WIDTH  = 2
);
    logic [N_INPUTS-1:0]            s_axis_tvalid;
    logic [N_INPUTS-1:0]            s_axis_tready;
    logic [N_INPUTS-1:0]            s_axis_tlast;
    logic [N_INPUTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic                           m_axis_tvalid;
    logic                           m_axis_tready;
    logic                           m_axis_tlast;
    logic [DATA_WIDTH-1:0]          m_axis_tdata;
    logic [SRC_WIDTH-1:0]           m_axis_tuser;

    modport master (
        input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tuser
    );

    modport slave (
        output s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tuser
    );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-atomic merge of N AXI-Stream sources into one stream.
// state | meaning
// IDLE  | no grant held; pick next enabled, valid source after last winner
// LOCK  | grant held until the tlast beat is accepted by the sink
module axis_packet_arbiter #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int SRC_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_INPUTS-1:0]   i_enable,
    axis_packet_arbiter_if.master bus,
    output logic                  o_busy,
    output logic [N_INPUTS-1:0]   o_grant
);
    typedef enum logic {IDLE, LOCK} state_t;

    localparam logic [SRC_WIDTH-1:0] LAST_RST = SRC_WIDTH'(N_INPUTS - 1);
    localparam logic [SRC_WIDTH:0]   N_EXT    = (SRC_WIDTH + 1)'(N_INPUTS);
    localparam logic [N_INPUTS-1:0]  ONE_HOT0 = N_INPUTS'(1);

    state_t                state_q, state_d;
    logic [N_INPUTS-1:0]   grant_q, grant_d;
    logic [SRC_WIDTH-1:0]  gidx_q, gidx_d;
    logic [SRC_WIDTH-1:0]  last_q, last_d;
    logic                  busy_q, busy_d;
    logic [N_INPUTS-1:0]   cand;
    logic [SRC_WIDTH:0]    idx;
    logic                  found;
    logic                  accept;

    // Merged stream is a pure mux of the granted source: no added latency.
    always_comb begin : datapath
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        bus.m_axis_tdata  = '0;
        bus.m_axis_tuser  = '0;
        bus.s_axis_tready = '0;
        if (state_q == LOCK) begin
            for (int k = 0; k < N_INPUTS; k++) begin
                if (grant_q[k]) begin
                    bus.m_axis_tvalid = bus.s_axis_tvalid[k];
                    bus.m_axis_tlast  = bus.s_axis_tlast[k];
                    bus.m_axis_tdata  = bus.s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            bus.m_axis_tuser  = gidx_q;
            bus.s_axis_tready = grant_q & {N_INPUTS{bus.m_axis_tready}};
        end
    end

    always_comb begin : fsm
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cand    = bus.s_axis_tvalid & i_enable;
        found   = 1'b0;
        idx     = '0;
        accept  = bus.m_axis_tvalid & bus.m_axis_tready;
        case (state_q)
            IDLE: begin
                // Search upward from last+1 with wrap; first hit wins.
                for (int i = 1; i <= N_INPUTS; i++) begin
                    idx = {1'b0, last_q} + (SRC_WIDTH + 1)'(i);
                    if (idx >= N_EXT) idx = idx - N_EXT;
                    if (!found && cand[idx[SRC_WIDTH-1:0]]) begin
                        found   = 1'b1;
                        state_d = LOCK;
                        gidx_d  = idx[SRC_WIDTH-1:0];
                        grant_d = ONE_HOT0 << idx[SRC_WIDTH-1:0];
                    end
                end
            end
            LOCK: begin
                if (accept && bus.m_axis_tlast) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOCK);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_RST;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_grant = grant_q;
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: arbitration order, packet atomicity,
// backpressure, enable masking, source stalls and mid-packet reset.
module tb_axis_packet_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int SW = 2;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [N-1:0]  i_enable;
    logic          o_busy;
    logic [N-1:0]  o_grant;
    int            n_cmp = 0;
    int            n_err = 0;

    axis_packet_arbiter_if #(.N_INPUTS(N), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) bus ();

    axis_packet_arbiter #(.N_INPUTS(N), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_enable(i_enable),
        .bus     (bus.master),
        .o_busy  (o_busy),
        .o_grant (o_grant)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int k, input logic v, input logic l, input logic [DW-1:0] d);
        bus.s_axis_tvalid[k]         = v;
        bus.s_axis_tlast[k]          = l;
        bus.s_axis_tdata[k*DW +: DW] = d;
    endtask

    task automatic clear_srcs();
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tdata  = '0;
    endtask

    initial begin
        int fair_order [6];
        int pkt [4];
        int k;
        int b;
        int c;
        logic r;

        fair_order = '{0, 1, 3, 0, 1, 3};
        pkt        = '{0, 0, 0, 0};
        i_enable   = '1;
        clear_srcs();
        bus.m_axis_tready = 1'b1;

        // Reset values
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        chk("rst_busy",   o_busy, 0);
        chk("rst_grant",  o_grant, 0);
        chk("rst_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_tlast",  bus.m_axis_tlast, 0);
        chk("rst_tdata",  bus.m_axis_tdata, 0);
        chk("rst_tuser",  bus.m_axis_tuser, 0);
        chk("rst_tready", bus.s_axis_tready, 0);

        // Fairness: sources 0,1,3 continuously offering 2-beat packets
        set_src(0, 1'b1, 1'b0, 16'h0000);
        set_src(1, 1'b1, 1'b0, 16'h0100);
        set_src(3, 1'b1, 1'b0, 16'h0300);
        for (int p = 0; p < 6; p++) begin
            k = fair_order[p];
            #1;
            chk("fair_gap_tvalid", bus.m_axis_tvalid, 0);
            chk("fair_gap_busy", o_busy, 0);
            tick();
            #1;
            chk("fair_grant", o_grant, 32'(1) << k);
            chk("fair_tuser", bus.m_axis_tuser, k);
            chk("fair_beat0", bus.m_axis_tdata, k * 256 + pkt[k] * 16);
            chk("fair_tlast0", bus.m_axis_tlast, 0);
            tick();
            set_src(k, 1'b1, 1'b1, 16'(k * 256 + pkt[k] * 16 + 1));
            #1;
            chk("fair_beat1", bus.m_axis_tdata, k * 256 + pkt[k] * 16 + 1);
            chk("fair_tlast1", bus.m_axis_tlast, 1);
            chk("fair_sready", bus.s_axis_tready, 32'(1) << k);
            tick();
            pkt[k]++;
            set_src(k, 1'b1, 1'b0, 16'(k * 256 + pkt[k] * 16));
        end
        clear_srcs();

        // Single source 2, three beats
        set_src(2, 1'b1, 1'b0, 16'h0001);
        #1;
        chk("single_idle_tvalid", bus.m_axis_tvalid, 0);
        tick();
        #1;
        chk("single_grant", o_grant, 4'b0100);
        chk("single_tuser", bus.m_axis_tuser, 2);
        chk("single_d0", bus.m_axis_tdata, 16'h0001);
        chk("single_busy0", o_busy, 1);
        tick();
        set_src(2, 1'b1, 1'b0, 16'h0004);
        #1;
        chk("single_d1", bus.m_axis_tdata, 16'h0004);
        chk("single_tlast1", bus.m_axis_tlast, 0);
        chk("single_busy1", o_busy, 1);
        tick();
        set_src(2, 1'b1, 1'b1, 16'h0009);
        #1;
        chk("single_d2", bus.m_axis_tdata, 16'h0009);
        chk("single_tlast2", bus.m_axis_tlast, 1);
        chk("single_busy2", o_busy, 1);
        tick();
        set_src(2, 1'b0, 1'b0, 16'h0000);
        #1;
        chk("single_busy_end", o_busy, 0);
        chk("single_grant_end", o_grant, 0);

        // Backpressure on source 1, ready pattern 1,0,0,1,0,0,...
        b = 0;
        c = 0;
        set_src(1, 1'b1, 1'b0, 16'h00A0);
        tick();
        while (b < 4 && c < 20) begin
            r = (c % 3 == 0);
            bus.m_axis_tready = r;
            #1;
            chk("bp_sready", bus.s_axis_tready, r ? 32'h2 : 32'h0);
            chk("bp_data", bus.m_axis_tdata, 16'h00A0 + 16'(b));
            chk("bp_tlast", bus.m_axis_tlast, (b == 3) ? 1 : 0);
            tick();
            if (r) begin
                b++;
                if (b < 4) set_src(1, 1'b1, b == 3, 16'h00A0 + 16'(b));
                else       set_src(1, 1'b0, 1'b0, 16'h0000);
            end
            c++;
        end
        bus.m_axis_tready = 1'b1;
        #1;
        chk("bp_busy_end", o_busy, 0);
        chk("bp_grant_end", o_grant, 0);

        // Enable mask: only source 1 eligible; disable mid-packet
        i_enable = 4'b1010;
        set_src(0, 1'b1, 1'b0, 16'h00E0);
        set_src(1, 1'b1, 1'b0, 16'h00F0);
        #1;
        chk("en_idle_tvalid", bus.m_axis_tvalid, 0);
        tick();
        i_enable = 4'b1000;
        #1;
        chk("en_grant", o_grant, 4'b0010);
        chk("en_d0", bus.m_axis_tdata, 16'h00F0);
        tick();
        set_src(1, 1'b1, 1'b1, 16'h00F1);
        #1;
        chk("en_d1", bus.m_axis_tdata, 16'h00F1);
        chk("en_tlast", bus.m_axis_tlast, 1);
        tick();
        set_src(1, 1'b1, 1'b0, 16'h00F2);
        #1;
        chk("en_busy_end", o_busy, 0);
        chk("en_grant_end", o_grant, 0);
        tick();
        #1;
        chk("en_no_grant1", o_grant, 0);
        chk("en_no_tvalid", bus.m_axis_tvalid, 0);
        tick();
        #1;
        chk("en_no_grant2", o_grant, 0);
        clear_srcs();
        i_enable = 4'b1111;

        // Source stall: source 0 drops tvalid 3 cycles while source 2 waits
        set_src(0, 1'b1, 1'b0, 16'h00B0);
        tick();
        set_src(2, 1'b1, 1'b1, 16'h00C0);
        #1;
        chk("stall_grant", o_grant, 4'b0001);
        chk("stall_d0", bus.m_axis_tdata, 16'h00B0);
        tick();
        set_src(0, 1'b0, 1'b0, 16'h00B0);
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_tvalid", bus.m_axis_tvalid, 0);
            chk("stall_hold", o_grant, 4'b0001);
            chk("stall_sready", bus.s_axis_tready, 4'b0001);
            tick();
        end
        set_src(0, 1'b1, 1'b1, 16'h00B1);
        #1;
        chk("stall_d1", bus.m_axis_tdata, 16'h00B1);
        chk("stall_tvalid1", bus.m_axis_tvalid, 1);
        chk("stall_tlast", bus.m_axis_tlast, 1);
        tick();
        set_src(0, 1'b0, 1'b0, 16'h0000);
        #1;
        chk("stall_gap_grant", o_grant, 0);
        chk("stall_gap_tvalid", bus.m_axis_tvalid, 0);
        tick();
        #1;
        chk("stall_next_grant", o_grant, 4'b0100);
        chk("stall_next_tuser", bus.m_axis_tuser, 2);
        chk("stall_next_data", bus.m_axis_tdata, 16'h00C0);
        tick();
        clear_srcs();

        // Reset after beat 2 of a 5-beat packet from source 1
        set_src(1, 1'b1, 1'b0, 16'h00D0);
        tick();
        #1;
        chk("mrst_grant", o_grant, 4'b0010);
        chk("mrst_d0", bus.m_axis_tdata, 16'h00D0);
        tick();
        set_src(1, 1'b1, 1'b0, 16'h00D1);
        #1;
        chk("mrst_d1", bus.m_axis_tdata, 16'h00D1);
        tick();
        set_src(1, 1'b1, 1'b0, 16'h00D2);
        i_rst = 1'b1;
        #1;
        chk("mrst_d2", bus.m_axis_tdata, 16'h00D2);
        tick();
        #1;
        chk("mrst_busy", o_busy, 0);
        chk("mrst_grant0", o_grant, 0);
        chk("mrst_tvalid", bus.m_axis_tvalid, 0);
        chk("mrst_tlast", bus.m_axis_tlast, 0);
        chk("mrst_tdata", bus.m_axis_tdata, 0);
        chk("mrst_sready", bus.s_axis_tready, 0);
        i_rst = 1'b0;
        clear_srcs();
        set_src(0, 1'b1, 1'b0, 16'h0050);
        set_src(3, 1'b1, 1'b0, 16'h0053);
        tick();
        #1;
        chk("mrst_rr_grant", o_grant, 4'b0001);
        chk("mrst_rr_tuser", bus.m_axis_tuser, 0);
        chk("mrst_rr_data", bus.m_axis_tdata, 16'h0050);
        clear_srcs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
